// File: rtl/alu_seq_if.sv
// Shared ALU control encodings and the request/ALU bundle seen by alu_seq.
// The package lives here so the interface and the sequencer share one definition.
package alu_seq_pkg;

  typedef enum logic [1:0] {NO_SH = 2'd0, SH_LEFT = 2'd1, SH_RIGHT = 2'd2, SH_ROT = 2'd3} alu_sh_e;
  typedef enum logic [1:0] {SH_OE = 2'd0, RES_OE = 2'd1, BUS_OE = 2'd2, NO_OE = 2'd3} alu_oe_e;
  typedef enum logic [1:0] {NO_LD = 2'd0, BUS_LD = 2'd1, RES_LD = 2'd2, HOLD_LD = 2'd3} alu_ld_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
    OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7
  } alu_opc_e;

  // {r,s,v} function select; every arithmetic op, compare included, uses the adder
  function automatic logic [2:0] fn_sel(alu_opc_e op);
    case (op)
      OP_AND:  return 3'b010;
      OP_XOR:  return 3'b100;
      OP_OR:   return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic is_sub(alu_opc_e op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  // Subtraction is A + ~B + 1, so a borrow-in appears as an inverted carry
  function automatic logic cin0(alu_opc_e op, logic c);
    case (op)
      OP_ADC:        return c;
      OP_SUB, OP_CP: return 1'b1;
      OP_SBC:        return ~c;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

interface alu_seq_if;
  import alu_seq_pkg::*;

  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;

  logic [7:0] alu_op;
  alu_sh_e    alu_sh;
  alu_oe_e    alu_oe;
  alu_ld_e    alu_la;
  alu_ld_e    alu_lb;
  logic       alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;

  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       result_we;
  logic       fz, fn, fh, fc;

  modport slave (
    input  start, op, a, b, c_in, alu_result, alu_zero, alu_carry,
    output alu_op, alu_sh, alu_oe, alu_la, alu_lb,
           alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h,
           busy, done, result, result_we, fz, fn, fh, fc
  );

  modport master (
    output start, op, a, b, c_in, alu_result, alu_zero, alu_carry,
    input  alu_op, alu_sh, alu_oe, alu_la, alu_lb,
           alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h,
           busy, done, result, result_we, fz, fn, fh, fc
  );

endinterface

// File: rtl/alu_seq.sv
// Micro-sequencer for the nibble-serial ALU: load A, low nibble, high nibble,
// then capture result and Z/N/H/C flags. All outputs come straight from flops.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LO, S_HI, S_DONE} state_e;

  state_e     state_q, state_d;
  alu_opc_e   op_q;
  logic [7:0] b_q;
  logic       c_q;
  logic       hc_q;

  logic [7:0] alu_op_q;
  alu_sh_e    sh_q;
  alu_oe_e    oe_q;
  alu_ld_e    la_q, lb_q;
  logic       r_q, s_q, v_q, ne_q, ci_q, l_q, h_q;
  logic       busy_q, done_q, we_q;
  logic [7:0] result_q;
  logic       fz_q, fn_q, fh_q, fc_q;

  logic accept;
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

  // NOTE: state_d is given a value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LDA;
      S_LDA:   state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_LDA : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all flops see pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      b_q      <= '0;
      c_q      <= 1'b0;
      hc_q     <= 1'b0;
      alu_op_q <= '0;
      sh_q     <= NO_SH;
      oe_q     <= SH_OE;
      la_q     <= NO_LD;
      lb_q     <= NO_LD;
      {r_q, s_q, v_q, ne_q, ci_q, l_q, h_q} <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      {fz_q, fn_q, fh_q, fc_q} <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        op_q <= alu_opc_e'(bus.op);
        b_q  <= bus.b;
        c_q  <= bus.c_in;
      end

      // Controls are decoded from the state being entered so they line up with it.
      alu_op_q <= '0;
      sh_q     <= NO_SH;
      oe_q     <= SH_OE;
      la_q     <= NO_LD;
      lb_q     <= NO_LD;
      {r_q, s_q, v_q, ne_q, ci_q, l_q, h_q} <= '0;
      case (state_d)
        S_LDA: begin
          alu_op_q <= bus.a;
          la_q     <= BUS_LD;
        end
        S_LO: begin
          alu_op_q          <= b_q;
          lb_q              <= BUS_LD;
          {r_q, s_q, v_q}   <= fn_sel(op_q);
          ne_q              <= is_sub(op_q);
          ci_q              <= cin0(op_q, c_q);
          l_q               <= 1'b1;
        end
        S_HI: begin
          {r_q, s_q, v_q}   <= fn_sel(op_q);
          ne_q              <= is_sub(op_q);
          h_q               <= 1'b1;
          oe_q              <= RES_OE;
        end
        default: ;
      endcase

      busy_q <= (state_d == S_LDA) || (state_d == S_LO) || (state_d == S_HI);
      done_q <= (state_q == S_HI);
      we_q   <= (state_q == S_HI) && (op_q != OP_CP);

      if (state_q == S_LO) hc_q <= bus.alu_carry;

      if (state_q == S_HI) begin
        result_q <= bus.alu_result;
        fz_q     <= bus.alu_zero;
        fn_q     <= is_sub(op_q);
        case (op_q)
          OP_ADD, OP_ADC: begin
            fh_q <= hc_q;
            fc_q <= bus.alu_carry;
          end
          OP_SUB, OP_SBC, OP_CP: begin
            fh_q <= ~hc_q;
            fc_q <= ~bus.alu_carry;
          end
          OP_AND: begin
            fh_q <= 1'b1;
            fc_q <= 1'b0;
          end
          default: begin
            fh_q <= 1'b0;
            fc_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.alu_op    = alu_op_q;
  assign bus.alu_sh    = sh_q;
  assign bus.alu_oe    = oe_q;
  assign bus.alu_la    = la_q;
  assign bus.alu_lb    = lb_q;
  assign bus.alu_r     = r_q;
  assign bus.alu_s     = s_q;
  assign bus.alu_v     = v_q;
  assign bus.alu_ne    = ne_q;
  assign bus.alu_ci    = ci_q;
  assign bus.alu_l     = l_q;
  assign bus.alu_h     = h_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_we = we_q;
  assign bus.fz        = fz_q;
  assign bus.fn        = fn_q;
  assign bus.fh        = fh_q;
  assign bus.fc        = fc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: the bench plays the ALU, feeding hand-computed
// nibble carries and results, and checks every control and flag cycle by cycle.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_seq_if bus ();

  alu_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // One operation: request, ALU responses, and the expected sequencer behaviour.
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       lo_c;    // ALU carry out of the low nibble
    logic [7:0] res;     // ALU result in HI
    logic       zero;
    logic       carry;   // ALU carry out of the high nibble
    logic [2:0] rsv;
    logic       ne;
    logic       ci;
    logic [3:0] zhnc;    // expected {fz, fn, fh, fc}
    logic       we;
    logic       poke;    // pulse start during LO
  } op_vec_t;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic launch(op_vec_t v);
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.c_in  = v.cin;
    bus.start = 1'b1;
  endtask

  // Runs LDA..DONE from just after launch; returns at the DONE-cycle negedge.
  task automatic finish_op(string name, op_vec_t v);
    @(negedge clk);  // LDA
    bus.start = 1'b0;
    check({name, " lda_busy"}, 8'(bus.busy), 8'd1);
    check({name, " lda_op"},   bus.alu_op, v.a);
    check({name, " lda_la"},   8'(bus.alu_la), 8'(BUS_LD));
    @(negedge clk);  // LO
    check({name, " lo_op"},  bus.alu_op, v.b);
    check({name, " lo_ld"},  8'({bus.alu_la, bus.alu_lb}), 8'({NO_LD, BUS_LD}));
    check({name, " lo_rsv"}, 8'({bus.alu_r, bus.alu_s, bus.alu_v}), 8'(v.rsv));
    check({name, " lo_ne_ci"}, 8'({bus.alu_ne, bus.alu_ci}), 8'({v.ne, v.ci}));
    check({name, " lo_lh_oe"}, 8'({bus.alu_l, bus.alu_h, bus.alu_oe}), 8'({2'b10, SH_OE}));
    bus.alu_carry = v.lo_c;
    if (v.poke) bus.start = 1'b1;
    @(negedge clk);  // HI
    bus.start = 1'b0;
    check({name, " hi_lh_ci"}, 8'({bus.alu_l, bus.alu_h, bus.alu_ci}), 8'b010);
    check({name, " hi_oe"},    8'(bus.alu_oe), 8'(RES_OE));
    check({name, " hi_rsv_ne"}, 8'({bus.alu_r, bus.alu_s, bus.alu_v, bus.alu_ne}), 8'({v.rsv, v.ne}));
    check({name, " hi_busy_done"}, 8'({bus.busy, bus.done}), 8'b10);
    bus.alu_result = v.res;
    bus.alu_zero   = v.zero;
    bus.alu_carry  = v.carry;
    @(negedge clk);  // DONE
    check({name, " done_busy_we"}, 8'({bus.done, bus.busy, bus.result_we}), 8'({2'b10, v.we}));
    check({name, " result"}, bus.result, v.res);
    check({name, " flags"},  8'({bus.fz, bus.fn, bus.fh, bus.fc}), 8'(v.zhnc));
    check({name, " done_idle_ctl"}, 8'({bus.alu_l, bus.alu_h, bus.alu_oe, bus.alu_la}), 8'({2'b00, SH_OE, NO_LD}));
  endtask

  op_vec_t v_or, v_add, v_sub, v_sbc, v_adc, v_and, v_xor, v_cp;

  initial begin
    //            op a      b      cin   lo_c  res    zero  carry rsv     ne    ci    zhnc     we    poke
    v_or  = '{3'd6, 8'h5A, 8'h0F, 1'b0, 1'b1, 8'h5F, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
    v_add = '{3'd0, 8'h3A, 8'hC6, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1};
    v_sub = '{3'd2, 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0};
    v_sbc = '{3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0};
    v_adc = '{3'd1, 8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    v_and = '{3'd4, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0};
    v_xor = '{3'd5, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0};
    v_cp  = '{3'd7, 8'h42, 8'h42, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0};

    clk = 1'b0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.alu_result = '0;
    bus.alu_zero = 1'b0;
    bus.alu_carry = 1'b0;

    repeat (2) @(negedge clk);
    check("rst busy_done_we", 8'({bus.busy, bus.done, bus.result_we}), 8'd0);
    check("rst result", bus.result, 8'h00);
    check("rst flags", 8'({bus.fz, bus.fn, bus.fh, bus.fc}), 8'd0);
    check("rst alu_op", bus.alu_op, 8'h00);
    check("rst sel", 8'({bus.alu_sh, bus.alu_oe, bus.alu_la, bus.alu_lb}), 8'({NO_SH, SH_OE, NO_LD, NO_LD}));
    check("rst bits", 8'({bus.alu_r, bus.alu_s, bus.alu_v, bus.alu_ne, bus.alu_ci, bus.alu_l, bus.alu_h}), 8'd0);

    reset_n = 1'b1;
    @(negedge clk);

    launch(v_or);
    finish_op("or", v_or);
    @(negedge clk);
    check("or after_done", 8'({bus.done, bus.busy, bus.result_we}), 8'd0);
    check("or held_result", bus.result, 8'h5F);

    // Start pulsed during LO must not spawn a second operation.
    launch(v_add);
    finish_op("add", v_add);
    @(negedge clk);
    check("add poke_ignored", 8'({bus.done, bus.busy}), 8'd0);
    @(negedge clk);
    check("add still_idle", 8'({bus.done, bus.busy}), 8'd0);

    // Back-to-back: a new start issued in DONE is accepted on that edge.
    launch(v_sub);
    finish_op("sub", v_sub);
    launch(v_sbc);
    finish_op("sbc", v_sbc);
    launch(v_adc);
    finish_op("adc", v_adc);
    launch(v_and);
    finish_op("and", v_and);
    launch(v_xor);
    finish_op("xor", v_xor);
    launch(v_cp);
    finish_op("cp", v_cp);
    @(negedge clk);

    // Reset during HI aborts the operation with no done pulse.
    launch(v_or);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.alu_carry = 1'b1;
    @(negedge clk);
    check("abort in_hi", 8'({bus.busy, bus.alu_h}), 8'b11);
    bus.alu_result = 8'hAA;
    reset_n = 1'b0;
    #1;
    check("abort busy_done_we", 8'({bus.busy, bus.done, bus.result_we}), 8'd0);
    check("abort flags", 8'({bus.fz, bus.fn, bus.fh, bus.fc}), 8'd0);
    check("abort result", bus.result, 8'h00);
    check("abort ctl", 8'({bus.alu_h, bus.alu_oe, bus.alu_ne}), 8'({1'b0, SH_OE, 1'b0}));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort no_done", 8'({bus.done, bus.busy}), 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
